// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: source count, FSM
// encoding, register word offsets and command codes.
package int_ctrl_pkg;

    localparam int NSRC = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    // Word offsets within the device window (PrAddr[3:2])
    localparam logic [1:0] PEND = 2'd0;
    localparam logic [1:0] MASK = 2'd1;
    localparam logic [1:0] CMD  = 2'd2;
    localparam logic [1:0] CTRL = 2'd3;

    // Command codes written to CMD[1:0]
    localparam logic [1:0] CMD_ACK = 2'b01;
    localparam logic [1:0] CMD_EOI = 2'b10;

    // One-hot vector with only bit idx set
    function automatic logic [NSRC-1:0] onehot(input logic [2:0] idx);
        return NSRC'(1) << idx;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Bridge-side register bus of the interrupt controller. The bridge drives
// write enable, word address and write data; the controller returns read data.
interface int_ctrl_if;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output we, output addr, output wd, input rd);
    modport slave  (input we, input addr, input wd, output rd);
endinterface

// File: rtl/int_ctrl_prio_enc6.sv
// Six-input priority encoder: the lowest set index wins.
module prio_enc6
    import int_ctrl_pkg::*;
(
    input  logic [NSRC-1:0] req_i,
    output logic [2:0]      idx_o,
    output logic            vld_o
);

    // Scan from the top down so the lowest set bit overwrites last
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 3'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller in front of CP0 HWInt. Latches, masks and
// prioritises six sources and presents one request at a time; the CPU claims
// it with ACK and retires it with EOI. Register reads have no side effects.
module int_ctrl
    import int_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    int_ctrl_if.slave       bus,
    output logic [NSRC-1:0] hwint,
    output logic            irq
);

    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] mask_q, mode_q;
    logic            en_q;
    logic [2:0]      vec_q, vec_d;
    state_t          state_q, state_d;

    logic            wr_pend, wr_mask, wr_cmd, wr_ctrl;
    logic            cmd_ack, cmd_eoi;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] edge_set;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;
    logic [2:0]      enc_idx;
    logic            enc_vld;
    logic            unused_wd;

    assign wr_pend = bus.we && (bus.addr == PEND);
    assign wr_mask = bus.we && (bus.addr == MASK);
    assign wr_cmd  = bus.we && (bus.addr == CMD);
    assign wr_ctrl = bus.we && (bus.addr == CTRL);

    assign cmd_ack = wr_cmd && (bus.wd[1:0] == CMD_ACK);
    assign cmd_eoi = wr_cmd && (bus.wd[1:0] == CMD_EOI);

    // Write-data bits with no register behind them
    assign unused_wd = ^{bus.wd[31:14], bus.wd[7:6]};

    assign elig     = en_q ? (pend_q & mask_q) : '0;
    assign edge_set = src & ~prev_q;
    assign w1c      = wr_pend ? bus.wd[NSRC-1:0] : '0;
    // An ACK only retires the claimed source, and only while it is in REQ
    assign ack_clr  = (cmd_ack && (state_q == REQ)) ? onehot(vec_q) : '0;

    // Edge bits: hold, clear by W1C/ACK, and a fresh edge overrides any clear.
    // Level bits simply follow the source one cycle late.
    assign pend_d = (mode_q & ((pend_q & ~(w1c | ack_clr)) | edge_set))
                  | (~mode_q & src);

    prio_enc6 u_prio (
        .req_i (elig),
        .idx_o (enc_idx),
        .vld_o (enc_vld)
    );

    // Pending bits and the edge-detect history
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            prev_q <= '0;
        end else begin
            pend_q <= pend_d;
            prev_q <= src;
        end
    end

    // Software-programmed configuration: mask, mode and global enable
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            mode_q <= '0;
            en_q   <= 1'b0;
        end else begin
            if (wr_mask) begin
                mask_q <= bus.wd[5:0];
                mode_q <= bus.wd[13:8];
            end
            if (wr_ctrl) begin
                en_q <= bus.wd[0];
            end
        end
    end

    // FSM state and latched vector
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    // Next-state logic; vec is frozen once a request is presented, and an
    // ACK takes precedence over a simultaneous withdrawal
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                if (enc_vld) begin
                    vec_d   = enc_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cmd_ack) begin
                    state_d = SERV;
                end else if (!elig[vec_q]) begin
                    state_d = IDLE;
                end
            end
            SERV: begin
                if (cmd_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hwint = (state_q == REQ) ? onehot(vec_q) : '0;
    assign irq   = |hwint;

    // Side-effect-free register read mux
    always_comb begin
        bus.rd = '0;
        case (bus.addr)
            PEND:    bus.rd = {26'b0, pend_q};
            MASK:    bus.rd = {18'b0, mode_q, 2'b0, mask_q};
            CMD:     bus.rd = {irq, (state_q == SERV), 27'b0, vec_q};
            CTRL:    bus.rd = {31'b0, en_q};
            default: bus.rd = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset state, basic request, priority,
// withdrawal, level mode, set-vs-clear, ignored commands, reset mid-service.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [5:0]  src;
    logic [5:0]  hwint;
    logic        irq;
    logic [31:0] d;
    int          n_cmp;
    int          n_err;

    int_ctrl_if bus ();

    int_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .bus   (bus),
        .hwint (hwint),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = v;
        tick();
        bus.we   = 1'b0;
        bus.wd   = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.rd;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        src      = '0;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.wd   = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("rst_rd%0d", a), d, 32'h0);
        end
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_hwint", {26'b0, hwint}, 32'h0);

        // Basic request on source 0 (edge mode)
        wr(MASK, 32'h0000_0101);
        wr(CTRL, 32'h1);
        rd(MASK, d);  check("mask_rb", d, 32'h0000_0101);
        rd(CTRL, d);  check("ctrl_rb", d, 32'h1);
        src = 6'b000001;
        tick();
        src = '0;
        check("basic_t1_irq", {31'b0, irq}, 32'h0);
        tick();
        check("basic_irq", {31'b0, irq}, 32'h1);
        check("basic_hwint", {26'b0, hwint}, 32'h1);
        rd(CMD, d);   check("basic_cmd", d, 32'h8000_0000);
        wr(CMD, 32'h1);
        check("ack_hwint", {26'b0, hwint}, 32'h0);
        rd(PEND, d);  check("ack_pend", d, 32'h0);
        rd(CMD, d);   check("ack_cmd", d, 32'h4000_0000);
        wr(CMD, 32'h2);
        rd(CMD, d);   check("eoi_cmd", d, 32'h0);

        // Priority: sources 3 and 1 together
        wr(MASK, 32'h0000_3F3F);
        src = 6'b001010;
        tick();
        src = '0;
        tick();
        check("prio_hwint1", {26'b0, hwint}, 32'h02);
        rd(CMD, d);   check("prio_cmd1", d, 32'h8000_0001);
        rd(PEND, d);  check("prio_pend", d, 32'h0A);
        wr(CMD, 32'h1);
        wr(CMD, 32'h2);
        check("prio_gap_irq", {31'b0, irq}, 32'h0);
        tick();
        check("prio_hwint3", {26'b0, hwint}, 32'h08);
        rd(CMD, d);   check("prio_cmd3", d, 32'h8000_0003);
        wr(CMD, 32'h1);
        wr(CMD, 32'h2);

        // Withdrawal by masking while in REQ on source 2
        src = 6'b000100;
        tick();
        src = '0;
        tick();
        check("wd_irq_on", {31'b0, irq}, 32'h1);
        wr(MASK, 32'h0000_3F00);
        tick();
        check("wd_irq_off", {31'b0, irq}, 32'h0);
        rd(CMD, d);   check("wd_cmd", d, 32'h0000_0002);
        rd(PEND, d);  check("wd_pend", d, 32'h04);
        wr(MASK, 32'h0000_3F04);
        check("wd_reirq_t1", {31'b0, irq}, 32'h0);
        tick();
        check("wd_reirq", {26'b0, hwint}, 32'h04);
        wr(CMD, 32'h1);
        wr(CMD, 32'h2);
        rd(PEND, d);  check("wd_pend_clr", d, 32'h0);

        // Level mode on source 5 (mode bits all zero)
        wr(MASK, 32'h0020_0020);
        rd(MASK, d);  check("lvl_mask_rb", d, 32'h20);
        src = 6'b100000;
        tick();
        tick();
        check("lvl_hwint", {26'b0, hwint}, 32'h20);
        wr(CMD, 32'h1);
        rd(PEND, d);  check("lvl_pend_serv", d, 32'h20);
        wr(PEND, 32'h20);
        rd(PEND, d);  check("lvl_w1c_ignored", d, 32'h20);
        wr(CMD, 32'h2);
        check("lvl_gap_irq", {31'b0, irq}, 32'h0);
        tick();
        check("lvl_rereq", {26'b0, hwint}, 32'h20);
        src = '0;
        tick();
        tick();
        check("lvl_drop_irq", {31'b0, irq}, 32'h0);
        rd(CMD, d);   check("lvl_drop_cmd", d, 32'h0000_0005);

        // Same-cycle edge set and W1C clear: set wins; plain W1C clears
        wr(MASK, 32'h0000_3F00);
        src = 6'b000001;
        wr(PEND, 32'h1);
        src = '0;
        rd(PEND, d);  check("setclr_pend", d, 32'h01);
        wr(PEND, 32'h1);
        rd(PEND, d);  check("w1c_pend", d, 32'h0);

        // EOI in IDLE ignored
        wr(CMD, 32'h2);
        rd(CMD, d);   check("eoi_idle", d, 32'h0000_0005);

        // Enter SERV with PEND=0x06, then ACK and bad codes in SERV ignored
        wr(MASK, 32'h0000_3F3F);
        src = 6'b000110;
        tick();
        src = '0;
        tick();
        check("serv_hwint", {26'b0, hwint}, 32'h02);
        wr(CMD, 32'h1);
        src = 6'b000010;
        tick();
        src = '0;
        rd(PEND, d);  check("serv_pend", d, 32'h06);
        wr(CMD, 32'h1);
        wr(CMD, 32'h3);
        wr(CMD, 32'h0);
        rd(CMD, d);   check("ack_in_serv", d, 32'h4000_0001);
        rd(PEND, d);  check("ack_in_serv_pend", d, 32'h06);

        // Reset mid-service
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("mrst_rd%0d", a), d, 32'h0);
        end
        check("mrst_irq", {31'b0, irq}, 32'h0);
        for (int k = 0; k < 5; k++) tick();
        check("mrst_noreq", {26'b0, hwint}, 32'h0);
        rd(CMD, d);   check("mrst_cmd", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
